apu_envelope_length_unit: RTL

- Per-channel envelope generator and length counter for the NES APU pulse and noise channels.
- Sits directly downstream of the APU frame counter and consumes its e_pulse (~240 Hz) and l_pulse (~120 Hz) single-clk strobes.
- Driven by CPU register writes for $4000/$400C control, $4003/$400F length load, and the $4015 enable bit.
- Produces the 4-bit channel volume and the length-active status used by the channel mixer and the $4015 read-back.

---
 rtl/apu_pkg.sv | 24 ++
 rtl/apu_envelope.sv | 48 ++++
 rtl/apu_envelope_length_unit.sv | 75 +++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared types, constants and helpers for the APU envelope / length-counter slice.
package apu_pkg;

    typedef struct packed {
        logic       halt;
        logic       const_vol;
        logic [3:0] vol;
    } ctrl_reg_t;

    // Length-counter load values, indexed by the 5-bit field of $4003/$400F.
    localparam logic [7:0] LENGTH_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    // A held strobe counts once in edge mode, every cycle in level mode.
    function automatic logic wren_accept(input logic wren, input logic prev_wren,
                                         input bit edge_mode);
        return edge_mode ? (wren & ~prev_wren) : wren;
    endfunction

endpackage

// File: rtl/apu_envelope.sv
// Envelope generator: start flag, divider, decay level and registered volume mux.
module apu_envelope
    import apu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      e_pulse,
    input  logic      start,
    input  ctrl_reg_t ctrl,
    output logic [3:0] volume
);

    logic       start_flag;
    logic [3:0] divider;
    logic [3:0] decay;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_flag <= 1'b0;
            divider    <= 4'd0;
            decay      <= 4'd0;
            volume     <= 4'd0;
        end else begin
            if (e_pulse) begin
                if (start_flag) begin
                    start_flag <= 1'b0;
                    decay      <= 4'd15;
                    divider    <= ctrl.vol;
                end else if (divider == 4'd0) begin
                    divider <= ctrl.vol;
                    if (decay != 4'd0) begin
                        decay <= decay - 4'd1;
                    end else if (ctrl.halt) begin
                        decay <= 4'd15;
                    end
                end else begin
                    divider <= divider - 4'd1;
                end
            end
            // Placed after the envelope step so a coincident e_pulse sees the old flag.
            if (start) begin
                start_flag <= 1'b1;
            end
            volume <= ctrl.const_vol ? ctrl.vol : decay;
        end
    end

endmodule

// File: rtl/apu_envelope_length_unit.sv
// Per-channel envelope + length counter: register write decode, enable and length state.
module apu_envelope_length_unit
    import apu_pkg::*;
#(
    parameter bit WREN_EDGE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e_pulse,
    input  logic       l_pulse,
    input  logic       ctrl_wren,
    input  logic [5:0] ctrl_data,
    input  logic       len_wren,
    input  logic [4:0] len_index,
    input  logic       en_wren,
    input  logic       en_data,
    output logic [3:0] volume,
    output logic       length_active,
    output logic [7:0] length_count
);

    ctrl_reg_t ctrl_q;
    logic      enabled;
    logic      prev_ctrl_wren;
    logic      prev_len_wren;
    logic      prev_en_wren;
    logic      ctrl_acc;
    logic      len_acc;
    logic      en_acc;

    assign ctrl_acc = wren_accept(ctrl_wren, prev_ctrl_wren, WREN_EDGE);
    assign len_acc  = wren_accept(len_wren,  prev_len_wren,  WREN_EDGE);
    assign en_acc   = wren_accept(en_wren,   prev_en_wren,   WREN_EDGE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q         <= '0;
            enabled        <= 1'b0;
            prev_ctrl_wren <= 1'b0;
            prev_len_wren  <= 1'b0;
            prev_en_wren   <= 1'b0;
            length_count   <= 8'd0;
        end else begin
            prev_ctrl_wren <= ctrl_wren;
            prev_len_wren  <= len_wren;
            prev_en_wren   <= en_wren;
            if (ctrl_acc) begin
                ctrl_q <= ctrl_reg_t'(ctrl_data);
            end
            if (en_acc) begin
                enabled <= en_data;
            end
            // Enable-clear beats a load, which beats the l_pulse decrement (old halt).
            if (en_acc && !en_data) begin
                length_count <= 8'd0;
            end else if (len_acc && enabled) begin
                length_count <= LENGTH_TABLE[len_index];
            end else if (l_pulse && length_count != 8'd0 && !ctrl_q.halt) begin
                length_count <= length_count - 8'd1;
            end
        end
    end

    assign length_active = (length_count != 8'd0);

    apu_envelope u_envelope (
        .clk     (clk),
        .rst     (rst),
        .e_pulse (e_pulse),
        .start   (len_acc),
        .ctrl    (ctrl_q),
        .volume  (volume)
    );

endmodule
